// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// Tags and valid bits live here; the data array is external and driven through
// data_addr/data_write/data_wdata, with combinational read data on data_rdata.
module cache_ctrl #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req,
    input  logic                              cpu_we,
    input  logic [31:0]                       cpu_addr,
    input  logic [31:0]                       cpu_wdata,
    output logic [31:0]                       cpu_rdata,
    output logic                              cpu_ready,
    input  logic                              flush,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] data_addr,
    output logic                              data_write,
    output logic [31:0]                       data_wdata,
    input  logic [31:0]                       data_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [31:0]                       mem_addr,
    output logic [31:0]                       mem_wdata,
    input  logic [31:0]                       mem_rdata,
    input  logic                              mem_ready
);

    localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;

    logic [LINES-1:0]        r_valid;
    logic [TAG_WIDTH-1:0]    r_tags [LINES];
    logic [31:2]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_hit;
    logic [OFFSET_WIDTH-1:0] r_cnt;

    // Fields of the live CPU address (used in IDLE)
    logic [TAG_WIDTH-1:0]    w_tag;
    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [OFFSET_WIDTH-1:0] w_off;
    // Fields of the latched request (used in REFILL/WRITE)
    logic [TAG_WIDTH-1:0]    w_ltag;
    logic [INDEX_WIDTH-1:0]  w_lidx;
    logic [OFFSET_WIDTH-1:0] w_loff;

    logic w_hit;
    logic w_latch;
    logic w_flush_all;
    logic w_fill_start;
    logic w_fill_step;
    logic w_fill_done;
    logic w_unused;

    assign w_tag  = cpu_addr[31 -: TAG_WIDTH];
    assign w_idx  = cpu_addr[31-TAG_WIDTH -: INDEX_WIDTH];
    assign w_off  = cpu_addr[2 +: OFFSET_WIDTH];
    assign w_ltag = r_addr[31 -: TAG_WIDTH];
    assign w_lidx = r_addr[31-TAG_WIDTH -: INDEX_WIDTH];
    assign w_loff = r_addr[2 +: OFFSET_WIDTH];

    // Byte-lane bits of the CPU address carry no information for word accesses
    assign w_unused = ^cpu_addr[1:0];

    assign w_hit = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

    // Next-state and all outputs; reset forces the handshake/data outputs low
    always_comb begin
        w_state_nx   = r_state;
        cpu_rdata    = '0;
        cpu_ready    = 1'b0;
        data_addr    = {w_idx, w_off};
        data_write   = 1'b0;
        data_wdata   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_latch      = 1'b0;
        w_flush_all  = 1'b0;
        w_fill_start = 1'b0;
        w_fill_step  = 1'b0;
        w_fill_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    // Flush wins over a same-cycle request; the request is retried next cycle
                    w_flush_all = 1'b1;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        w_latch    = 1'b1;
                        w_state_nx = S_WRITE;
                    end else if (w_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_rdata;
                    end else begin
                        w_latch      = 1'b1;
                        w_fill_start = 1'b1;
                        w_state_nx   = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                mem_req   = 1'b1;
                mem_addr  = {w_ltag, w_lidx, r_cnt, 2'b00};
                data_addr = {w_lidx, r_cnt};
                if (mem_ready) begin
                    data_write  = 1'b1;
                    data_wdata  = mem_rdata;
                    w_fill_step = 1'b1;
                    if (&r_cnt) begin
                        w_fill_done = 1'b1;
                        w_state_nx  = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_addr, 2'b00};
                mem_wdata = r_wdata;
                data_addr = {w_lidx, w_loff};
                if (mem_ready) begin
                    cpu_ready  = 1'b1;
                    w_state_nx = S_IDLE;
                    // Write-through: update the array only when the line was resident
                    if (r_hit) begin
                        data_write = 1'b1;
                        data_wdata = r_wdata;
                    end
                end
            end

            default: w_state_nx = S_IDLE;
        endcase

        if (rst) begin
            cpu_ready  = 1'b0;
            cpu_rdata  = '0;
            data_write = 1'b0;
            data_wdata = '0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Request latch, refill counter and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_flush_all) r_valid <= '0;
            if (w_latch) begin
                r_addr  <= cpu_addr[31:2];
                r_wdata <= cpu_wdata;
                r_hit   <= w_hit;
            end
            if (w_fill_start) begin
                // Invalidate up front so a partially refilled line never hits
                r_cnt          <= '0;
                r_valid[w_idx] <= 1'b0;
            end
            if (w_fill_step) r_cnt <= r_cnt + OFFSET_WIDTH'(1);
            if (w_fill_done) r_valid[w_lidx] <= 1'b1;
        end
    end

    // Tag store; contents are only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (w_fill_done) r_tags[w_lidx] <= w_ltag;
    end

endmodule
